// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: accepts load/store requests against a 1024-word
// backing store and returns in-order responses after a fixed latency.
module data_sram_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [7:0]  data_index,
  input  logic [3:0]  data_offset,
  input  logic [2:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  input  logic        bus_stall,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [2:0]       DEPTH_C  = 3'(DEPTH);
  localparam logic [1:0]       CD_INIT  = 2'(LATENCY - 1);

  logic [31:0]      mem [0:1023];
  logic [9:0]       word_addr;
  logic [31:0]      rd_word;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [2:0]       count;
  logic [DEPTH-1:0] q_vld;
  logic [1:0]       q_cd      [DEPTH];
  logic             q_is_load [DEPTH];
  logic [31:0]      q_rdata   [DEPTH];

  logic             accept;
  logic             retire;
  logic             unused_size;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Size and low offset bits carry no meaning here: the full word is always moved.
  assign unused_size = ^{data_size, data_offset[1:0]};

  assign word_addr    = {data_index, data_offset[3:2]};
  assign rd_word      = mem[word_addr];

  assign retire       = !reset && q_vld[head] && (q_cd[head] == 2'd0);
  assign data_addr_ok = !reset && data_req && !bus_stall &&
                        ((count < DEPTH_C) || retire);
  assign accept       = data_req && data_addr_ok;

  assign data_data_ok = retire;
  assign data_rdata   = (retire && q_is_load[head]) ? q_rdata[head] : 32'h0;

  // Backing store: byte-lane writes on store acceptance, never reset.
  always_ff @(posedge clk) begin
    if (accept && data_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_wstrb[i]) begin
          mem[word_addr][8*i +: 8] <= data_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response payload captured at acceptance; a full queue reuses the slot
  // being retired in the same cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_is_load[tail] <= !data_wr;
      q_rdata[tail]   <= data_wr ? 32'h0 : rd_word;
    end
  end

  // Queue control: valid bits, countdowns, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 3'd0;
      q_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_cd[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_vld[i] && (q_cd[i] != 2'd0)) begin
          q_cd[i] <= q_cd[i] - 2'd1;
        end
      end
      if (retire) begin
        q_vld[head] <= 1'b0;
        head        <= ptr_inc(head);
      end
      if (accept) begin
        q_vld[tail] <= 1'b1;
        q_cd[tail]  <= CD_INIT;
        tail        <= ptr_inc(tail);
      end
      case ({accept, retire})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
